// File: rtl/hynoc_local_pkg.sv
// Definitions shared by the router's local-port writer and reader:
// FSM encoding and the flit field layout.
package hynoc_local_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Header flit fields; payload flits reuse the same split for {seq, index}.
  localparam int SRC_MSB   = 31;
  localparam int SRC_LSB   = 16;
  localparam int ROUTE_MSB = 15;
  localparam int ROUTE_LSB = 0;

  // The last-flit flag always sits in the flit MSB.
  function automatic int flit_last_bit(input int flit_width);
    return flit_width - 1;
  endfunction

endpackage

// File: rtl/local_writer.sv
// Packet source for a router local input port: emits one header flit and
// 'length' payload flits into the port FIFO, one flit per non-full cycle.
module local_writer #(
  parameter int LOCAL_ID      = 0,
  parameter int PAYLOAD_WIDTH = 32,
  parameter int FLIT_WIDTH    = PAYLOAD_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  srst_n,
  input  logic                  start,
  input  logic [15:0]           route,
  input  logic [15:0]           length,
  output logic                  busy,
  output logic                  done,
  output logic                  write,
  input  logic                  full,
  output logic [FLIT_WIDTH-1:0] data
);

  import hynoc_local_pkg::*;

  localparam int          LAST_BIT = flit_last_bit(FLIT_WIDTH);
  localparam logic [15:0] SRC_ID   = LOCAL_ID[15:0];

  state_t                  state_r;
  logic [15:0]             length_r;
  logic [15:0]             k_r;
  logic [15:0]             pkt_seq_r;
  logic                    busy_r;
  logic                    done_r;
  logic [FLIT_WIDTH-1:0]   data_r;
  logic                    write_s;

  function automatic logic [FLIT_WIDTH-1:0] make_header(input logic [15:0] rt,
                                                        input logic        last);
    logic [FLIT_WIDTH-1:0] f;
    f                     = '0;
    f[LAST_BIT]           = last;
    f[SRC_MSB:SRC_LSB]    = SRC_ID;
    f[ROUTE_MSB:ROUTE_LSB] = rt;
    return f;
  endfunction

  function automatic logic [FLIT_WIDTH-1:0] make_payload(input logic [15:0] seq,
                                                         input logic [15:0] idx,
                                                         input logic        last);
    logic [FLIT_WIDTH-1:0] f;
    f                      = '0;
    f[LAST_BIT]            = last;
    f[SRC_MSB:SRC_LSB]     = seq;
    f[ROUTE_MSB:ROUTE_LSB] = idx;
    return f;
  endfunction

  // A flit moves only when the FIFO can take it; data_r holds until then.
  assign write_s = ((state_r == ST_HEADER) || (state_r == ST_PAYLOAD)) && !full;

  // Packet FSM with the flit register, sequence counter and status outputs.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_r   <= ST_IDLE;
      pkt_seq_r <= 16'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      data_r    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r  <= ST_HEADER;
            busy_r   <= 1'b1;
            length_r <= length;
            data_r   <= make_header(route, length == 16'd0);
          end
        end
        ST_HEADER: begin
          if (write_s) begin
            if (length_r == 16'd0) begin
              state_r   <= ST_DONE;
              done_r    <= 1'b1;
              pkt_seq_r <= pkt_seq_r + 16'd1;
            end else begin
              state_r <= ST_PAYLOAD;
              k_r     <= 16'd0;
              data_r  <= make_payload(pkt_seq_r, 16'd0, length_r == 16'd1);
            end
          end
        end
        ST_PAYLOAD: begin
          if (write_s) begin
            if (k_r == (length_r - 16'd1)) begin
              state_r   <= ST_DONE;
              done_r    <= 1'b1;
              pkt_seq_r <= pkt_seq_r + 16'd1;
            end else begin
              // Prepare flit k+1; it is last when k+2 equals the length.
              k_r    <= k_r + 16'd1;
              data_r <= make_payload(pkt_seq_r, k_r + 16'd1,
                                     (k_r + 16'd2) == length_r);
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign write = write_s;
  assign data  = data_r;

endmodule

// File: tb/tb_local_writer.sv
// Self-checking bench for local_writer: directed scenarios plus randomized
// back-pressure, checked against a flit-list model built from the packet rules.
module tb_local_writer;

  localparam int PW = 32;
  localparam int FW = PW + 1;

  logic          clk = 1'b0;
  logic          srst_n;
  logic          start;
  logic [15:0]   route;
  logic [15:0]   length;
  logic          busy;
  logic          done;
  logic          write;
  logic          full;
  logic [FW-1:0] data;

  always #5 clk = ~clk;

  local_writer #(.LOCAL_ID(3), .PAYLOAD_WIDTH(PW), .FLIT_WIDTH(FW)) dut (
    .clk(clk), .srst_n(srst_n), .start(start), .route(route), .length(length),
    .busy(busy), .done(done), .write(write), .full(full), .data(data)
  );

  int tests = 0;
  int fails = 0;

  // Monitor state (written only by the monitor process).
  int            cyc = 0;
  int            done_cnt = 0;
  int            last_done_cyc = 0;
  int            busy_cnt = 0;
  int            stab_err = 0;
  logic          hold_prev = 1'b0;
  logic [FW-1:0] data_prev = '0;
  logic [FW-1:0] got_q[$];
  int            got_cyc[$];

  // Reference model state.
  logic [FW-1:0] exp_q[$];
  logic [15:0]   seq_m = 16'd0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (write) begin
      got_q.push_back(data);
      got_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt      = done_cnt + 1;
      last_done_cyc = cyc;
    end
    if (busy) busy_cnt = busy_cnt + 1;
    // A flit offered while full must still be on data one cycle later.
    if (hold_prev && srst_n && (data !== data_prev)) stab_err = stab_err + 1;
    hold_prev = busy && !done && full && srst_n;
    data_prev = data;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] hdr_flit(input logic [15:0] r, input int len);
    logic [FW-1:0] f;
    f         = '0;
    f[FW-1]   = (len == 0);
    f[31:16]  = 16'd3;
    f[15:0]   = r;
    return f;
  endfunction

  function automatic logic [FW-1:0] pay_flit(input logic [15:0] seq, input int k, input int len);
    logic [FW-1:0] f;
    f         = '0;
    f[FW-1]   = (k == len - 1);
    f[31:16]  = seq;
    f[15:0]   = k[15:0];
    return f;
  endfunction

  task automatic expect_packet(input logic [15:0] r, input int len);
    exp_q.push_back(hdr_flit(r, len));
    for (int k = 0; k < len; k++) exp_q.push_back(pay_flit(seq_m, k, len));
    seq_m = seq_m + 16'd1;
  endtask

  task automatic check_q(input string tag, input int base);
    chk({tag, "_count"}, 64'(got_q.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got_q.size())
        chk($sformatf("%s_flit%0d", tag, i), 64'(got_q[base + i]), 64'(exp_q[i]));
    end
    chk({tag, "_stable"}, 64'(stab_err), 64'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    srst_n = 1'b0;
    start  = 1'b0;
    full   = 1'b0;
    tick();
    tick();
    srst_n = 1'b1;
    seq_m  = 16'd0;
  endtask

  // Waits for done_cnt to reach target while driving the full pattern.
  task automatic wait_done(input string tag, input int target, input int mode, input int s);
    for (int n = 0; n < 300; n++) begin
      settle();
      if (done_cnt >= target) break;
      tick();
      case (mode)
        1:       full = ($urandom_range(0, 2) == 0);
        2:       full = (cyc + 1 >= s + 3) && (cyc + 1 <= s + 5);
        default: full = 1'b0;
      endcase
    end
    chk({tag, "_done_seen"}, 64'(done_cnt >= target), 64'd1);
    full = 1'b0;
  endtask

  // Called at posedge+1 of an idle cycle; returns at posedge+1 of the cycle after done.
  task automatic run_packet(input string tag, input logic [15:0] r, input int len,
                            input int mode, output int s, output int base);
    int d0;
    d0     = done_cnt;
    s      = cyc;
    base   = got_q.size();
    start  = 1'b1;
    route  = r;
    length = len[15:0];
    full   = 1'b0;
    tick();
    start  = 1'b0;
    route  = 16'($urandom);
    length = 16'($urandom);
    wait_done(tag, d0 + 1, mode, s);
    tick();
  endtask

  initial begin
    int s, base, b0, d0, w0;
    logic [15:0] r;
    int len;

    srst_n = 1'b0; start = 1'b0; full = 1'b0; route = 16'd0; length = 16'd0;
    tick(); tick();
    settle();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_write", 64'(write), 64'd0);
    chk("rst_data", 64'(data), 64'd0);
    tick();
    srst_n = 1'b1;
    tick();

    // Three-flit packet with no back-pressure.
    b0 = busy_cnt;
    run_packet("len2", 16'h0012, 2, 0, s, base);
    expect_packet(16'h0012, 2);
    check_q("len2", base);
    for (int i = 0; i < 3; i++)
      if (base + i < got_cyc.size())
        chk($sformatf("len2_wcyc%0d", i), 64'(got_cyc[base + i]), 64'(s + 2 + i));
    chk("len2_done_cyc", 64'(last_done_cyc), 64'(s + 5));
    chk("len2_busy_cycles", 64'(busy_cnt - b0), 64'd4);
    settle();
    chk("len2_done_width", 64'(done), 64'd0);
    chk("len2_idle_busy", 64'(busy), 64'd0);
    tick();

    // Header-only packet.
    b0 = busy_cnt;
    d0 = done_cnt;
    run_packet("len0", 16'h0012, 0, 0, s, base);
    expect_packet(16'h0012, 0);
    check_q("len0", base);
    chk("len0_busy_cycles", 64'(busy_cnt - b0), 64'd2);
    chk("len0_done_count", 64'(done_cnt - d0), 64'd1);

    // Back-pressure on cycles 2-4 after the accepting cycle.
    run_packet("stall", 16'h0abc, 4, 2, s, base);
    expect_packet(16'h0abc, 4);
    check_q("stall", base);
    if (base + 1 < got_cyc.size())
      chk("stall_resume_cyc", 64'(got_cyc[base + 1]), 64'(s + 6));

    // Randomized packets under random back-pressure.
    for (int p = 0; p < 8; p++) begin
      r   = 16'($urandom);
      len = $urandom_range(0, 6);
      run_packet($sformatf("rnd%0d", p), r, len, 1, s, base);
      expect_packet(r, len);
      check_q($sformatf("rnd%0d", p), base);
    end

    // Start held for 10 cycles: one packet per busy period, restart right after done.
    do_reset();
    tick();
    d0     = done_cnt;
    s      = cyc;
    base   = got_q.size();
    start  = 1'b1;
    route  = 16'h0055;
    length = 16'd1;
    repeat (10) tick();
    start  = 1'b0;
    wait_done("hold", d0 + 3, 0, s);
    repeat (3) tick();
    chk("hold_packets", 64'(done_cnt - d0), 64'd3);
    for (int p = 0; p < 3; p++) begin
      expect_packet(16'h0055, 1);
      if (base + 2 * p < got_cyc.size())
        chk($sformatf("hold_hdr_cyc%0d", p), 64'(got_cyc[base + 2 * p]), 64'(s + 2 + 4 * p));
    end
    check_q("hold", base);

    // Reset in the middle of a long packet.
    base   = got_q.size();
    start  = 1'b1;
    route  = 16'h0077;
    length = 16'd8;
    tick();
    start  = 1'b0;
    for (int n = 0; n < 50; n++) begin
      settle();
      if (got_q.size() >= base + 4) break;
    end
    chk("midrst_progress", 64'(got_q.size() >= base + 4), 64'd1);
    tick();
    srst_n = 1'b0;
    tick();
    srst_n = 1'b1;
    seq_m  = 16'd0;
    settle();
    chk("midrst_write", 64'(write), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    d0 = done_cnt;
    w0 = got_q.size();
    repeat (12) tick();
    chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    chk("midrst_no_write", 64'(got_q.size() - w0), 64'd0);
    run_packet("midrst_seq", 16'h0078, 1, 0, s, base);
    expect_packet(16'h0078, 1);
    check_q("midrst_seq", base);

    // Sequence wrap: preload the counter just below the wrap point.
    force dut.pkt_seq_r = 16'hfffe;
    tick();
    release dut.pkt_seq_r;
    seq_m = 16'hfffe;
    run_packet("wrap_a", 16'h0101, 1, 0, s, base);
    expect_packet(16'h0101, 1);
    check_q("wrap_a", base);
    run_packet("wrap_b", 16'h0102, 0, 0, s, base);
    expect_packet(16'h0102, 0);
    check_q("wrap_b", base);
    run_packet("wrap_c", 16'h0103, 1, 0, s, base);
    expect_packet(16'h0103, 1);
    check_q("wrap_c", base);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/local_writer.md
LOCAL_WRITER -- requirements
Module: local_writer

Interface
REQ-001 SHALL have parameter LOCAL_ID, default 0: source ID placed in header flit bits [31:16].
REQ-002 SHALL have parameter PAYLOAD_WIDTH, default 32: payload bits per flit; must be at least 32.
REQ-003 SHALL have parameter FLIT_WIDTH, default PAYLOAD_WIDTH+1: flit width; MSB is the last-flit flag.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port srst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit: request one packet; sampled only in IDLE.
REQ-007 SHALL have port route, input, 16 bits: routing field, captured on accepted start.
REQ-008 SHALL have port length, input, 16 bits: payload flit count, captured on accepted start; 0 is legal.
REQ-009 SHALL have port busy, output, 1 bit: high while a packet is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse after the last flit is written.
REQ-011 SHALL have port write, output, 1 bit: FIFO write strobe into the router local input port.
REQ-012 SHALL have port full, input, 1 bit: FIFO full flag.
REQ-013 SHALL have port data, output, FLIT_WIDTH bits: flit driven to the FIFO.

Function
REQ-014 SHALL implement FSM states IDLE, HEADER, PAYLOAD, DONE.
- IDLE->HEADER on start=1.
- HEADER->PAYLOAD on a header write when length>0; HEADER->DONE on a header write when length=0.
- PAYLOAD->DONE on the last payload write.
- DONE->IDLE unconditionally after 1 cycle.
REQ-015 SHALL capture route and length and register the header flit on the accepted start edge; write SHALL first assert the following cycle if full=0.
REQ-016 SHALL drive write = (state is HEADER or PAYLOAD) and !full, combinationally; a flit SHALL count as transferred only on cycles with write=1.
REQ-017 SHALL hold data stable while full=1, and SHALL advance data only after a transfer.
REQ-018 SHALL format the header flit as {last, LOCAL_ID[15:0], route[15:0]}, with last=1 only when length=0; bits above 31 SHALL be zero.
REQ-019 SHALL format payload flit k (k = 0..length-1) as {last, pkt_seq[15:0], k[15:0]}, with last=1 only at k=length-1; upper bits SHALL be zero.
REQ-020 SHALL keep pkt_seq as a 16-bit counter that increments on each done pulse and wraps from 0xFFFF to 0x0000.
REQ-021 SHALL ignore start while busy=1; no request SHALL be queued.
REQ-022 SHALL assert busy in HEADER, PAYLOAD, and DONE, and SHALL deassert it in IDLE.
REQ-023 SHALL assert done only in DONE; start SHALL be accepted no earlier than the cycle after done.
REQ-024 SHALL use zero-bubble back-to-back transfers: one flit per cycle while full=0.
REQ-025 SHALL deliver length+1 flits per packet, with exactly one flit carrying last=1.

Reset
REQ-026 SHALL, when srst_n=0 at a clock edge, set state=IDLE, pkt_seq=0, busy=0, done=0, write=0, data=0.
REQ-027 SHALL abandon an in-progress packet on reset mid-packet, with no further writes and no done pulse.
REQ-028 SHALL NOT require reset on datapath registers other than data.

Structure
REQ-029 SHALL place the FSM state encoding, the FLIT_LAST_BIT offset, and the header field offsets (SRC [31:16], ROUTE [15:0]) in the shared package hynoc_local_pkg, also used by the local reader.
REQ-030 SHALL be a single flat module with no sub-module; RTL size is 120-400 lines.

Verification
REQ-031 SHALL cover: LOCAL_ID=3, route=0x0012, length=2, full=0 -> writes 0x0_0003_0012, 0x0_0000_0000, 0x1_0000_0001 on 3 consecutive cycles, then a done pulse.
REQ-032 SHALL cover: length=0 -> a single write 0x1_0003_0012, busy for 2 cycles, done once.
REQ-033 SHALL cover: length=4 with full=1 for cycles 2-4 after start -> data frozen while full, 5 writes total, payload k order preserved, no duplicates.
REQ-034 SHALL cover: start held high for 10 cycles with length=1 -> exactly one packet; a second packet starts the cycle after done with pkt_seq=1.
REQ-035 SHALL cover: srst_n=0 during PAYLOAD of a length=8 packet -> write=0 the next cycle, busy=0, no done, pkt_seq=0.
REQ-036 SHALL cover: 65536 packets with length=0 -> the next packet's payload shows pkt_seq=0x0000 (wrap); checked via a length=1 packet.
